load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access initiator that drives the word-addressed data memory (rd/wr/add_lines/d_in, registered d_out) on behalf of the pipeline.
- Accepts byte-addressed load/store requests over a valid/ready handshake and converts them to word accesses.
- Handles byte/halfword loads with sign or zero extension, and byte/halfword stores by read-modify-write.
- Returns one response per request over a valid/ready handshake.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words in the data memory; a word index >= DEPTH_WORDS is an access error.
ADDR_W, 32, width of req_addr and add_lines.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_wr  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data; sub-word data sits in the low bits.
resp_valid  out  1  response present.
resp_ready  in  1  consumer takes the response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned, illegal size, or out of range.
rd  out  1  memory read strobe.
wr  out  1  memory write strobe.
add_lines  out  ADDR_W  word index, equal to req_addr >> 2.
d_in  out  32  memory write data.
d_out  in  32  memory read data; valid the cycle after rd is sampled.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - rd, wr, resp_valid and resp_err go to 0; add_lines, d_in and resp_rdata go to 0.
  - req_ready is 1 once RST is deasserted.
- Registered outputs: rd, wr, add_lines, d_in, resp_* are registered or decoded purely from state flops. No combinational path from any input to any output.
- req_ready is 1 only in IDLE. A request is accepted on a clock edge where req_valid && req_ready; opcode, size, sign, address and data are latched then. req_valid outside IDLE is ignored.
- Error check at acceptance:
  - Error conditions: size 11; half with addr[0] != 0; word with addr[1:0] != 0; addr>>2 >= DEPTH_WORDS.
  - Result: go directly to RESP with resp_err=1 and resp_rdata=0. rd and wr are never asserted.
- States:
  - IDLE: waits for a request.
  - RD: rd=1 and add_lines=index for exactly one cycle.
  - RWAIT: rd=0; d_out is sampled at the end of this cycle.
  - WR: wr=1 for exactly one cycle, with add_lines and d_in valid.
  - RESP: resp_valid=1 until resp_ready is sampled high, then IDLE.
- Transitions:
  - Load: IDLE -> RD -> RWAIT -> RESP.
  - Word store: IDLE -> WR -> RESP.
  - Byte/half store: IDLE -> RD -> RWAIT -> WR -> RESP; d_in is the merged word.
- Latency, from the accept edge to the first cycle of resp_valid: load 3 cycles, word store 2, sub-word store 4, error 1.
- Lanes are little-endian; the byte lane is addr[1:0] and the half lane is addr[1].
  - Load extract: shift the selected lane down, then sign- or zero-extend to 32 bits.
  - Store merge: replace only the selected lane of the d_out word with the low bits of req_wdata; other lanes are unchanged.
- rd and wr are never high in the same cycle. At most one access is in flight.
- While in RESP, resp_rdata and resp_err stay stable until the handshake completes.
- Reset mid-operation: all strobes drop immediately. An interrupted store gives no guarantee on memory contents, and no response is produced for the aborted request.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum;
  - the default for DEPTH_WORDS.
- One combinational sub-module, lsu_lane_align, performs lane extract/extend for loads and lane merge for stores. The FSM lives in the top module.

Test Plan:
- Reset: hold RST for 3 cycles -> rd=wr=resp_valid=0 and outputs 0; req_ready=1 after release.
- Word store then word load:
  - store 0xDEADBEEF to 0x10 -> wr high for exactly 1 cycle with add_lines=4 and d_in=0xDEADBEEF; resp_valid 2 cycles after accept, err=0.
  - load from 0x10 -> rd high for 1 cycle; resp_rdata=0xDEADBEEF 3 cycles after accept.
- Sub-word:
  - store byte 0xA5 at 0x12 over 0xDEADBEEF -> rd, then wr with d_in=0xDEA5BEEF.
  - signed byte load at 0x12 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
  - signed half load at 0x12 -> 0xFFFFDEA5.
- Errors:
  - half load at 0x11 -> err=1, rdata=0, no rd/wr.
  - word store at 0x4000 -> err=1, no wr.
  - size 11 -> err=1.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable; req_ready=0; a pulsed req_valid is ignored. Raise resp_ready -> IDLE the next cycle.
- Reset mid-load: assert RST during RWAIT -> resp_valid and rd low immediately; after release, a word load at 0x10 still returns the stored data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// default geometry of the word-addressed data memory.
package lsu_pkg;

  localparam int DEPTH_WORDS_DEF = 4096;
  localparam int ADDR_W_DEF      = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RWAIT = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // Bit offset of the addressed lane inside a little-endian word.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lane);
    if (size == SZ_HALF) begin
      lane_shift = {lane[1], 4'b0000};
    end else begin
      lane_shift = {lane, 3'b000};
    end
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts and extends a load lane, and merges
// store data into the selected lane of a read-back word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt_s;
  logic [31:0] shifted_s;
  logic [31:0] mask_s;

  always_comb begin
    shamt_s     = lane_shift(size_i, lane_i);
    shifted_s   = rdata_i >> shamt_s;
    load_data_o = 32'h0000_0000;
    mask_s      = 32'h0000_0000;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = sign_ext_i ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                                 : {24'h00_0000, shifted_s[7:0]};
        mask_s      = 32'h0000_00FF;
      end
      SZ_HALF: begin
        load_data_o = sign_ext_i ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                                 : {16'h0000, shifted_s[15:0]};
        mask_s      = 32'h0000_FFFF;
      end
      SZ_WORD: begin
        load_data_o = rdata_i;
        mask_s      = 32'hFFFF_FFFF;
      end
      default: begin
        load_data_o = 32'h0000_0000;
        mask_s      = 32'h0000_0000;
      end
    endcase
    merged_o = (rdata_i & ~(mask_s << shamt_s)) | ((wdata_i & mask_s) << shamt_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed requests into word accesses on a
// registered-read data memory, using read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] add_lines,
  output logic [31:0]       d_in,
  input  logic [31:0]       d_out
);

  lsu_state_e        state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [31:0]       d_in_q, d_in_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              accept_s;
  logic              req_bad_s;
  logic              req_err_s;
  logic [ADDR_W-1:0] req_idx_s;
  logic [31:0]       load_data_s;
  logic [31:0]       merged_s;

  assign req_ready  = (state_q == ST_IDLE);
  assign accept_s   = req_valid && (state_q == ST_IDLE);
  assign req_idx_s  = {2'b00, req_addr[ADDR_W-1:2]};
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign add_lines  = add_q;
  assign d_in       = d_in_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    case (req_size)
      SZ_BYTE: req_bad_s = 1'b0;
      SZ_HALF: req_bad_s = req_addr[0];
      SZ_WORD: req_bad_s = (req_addr[1:0] != 2'b00);
      default: req_bad_s = 1'b1;
    endcase
    req_err_s = req_bad_s || (req_idx_s >= ADDR_W'(DEPTH_WORDS));
  end

  lsu_lane_align u_align (
    .size_i      (size_q),
    .sign_ext_i  (sign_q),
    .lane_i      (lane_q),
    .rdata_i     (d_out),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!req_valid) begin
          state_d = ST_IDLE;
        end else if (req_err_s) begin
          state_d = ST_RESP;
        end else if (req_wr && (req_size == SZ_WORD)) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD:    state_d = ST_RWAIT;
      ST_RWAIT: state_d = op_wr_q ? ST_WR : ST_RESP;
      ST_WR:    state_d = ST_RESP;
      ST_RESP:  state_d = resp_ready ? ST_IDLE : ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    op_wr_d      = op_wr_q;
    size_d       = size_q;
    sign_d       = sign_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    add_d        = add_q;
    d_in_d       = d_in_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    rd_d         = (state_d == ST_RD);
    wr_d         = (state_d == ST_WR);
    resp_valid_d = (state_d == ST_RESP);
    if (accept_s) begin
      op_wr_d = req_wr;
      size_d  = req_size;
      sign_d  = req_signed;
      lane_d  = req_addr[1:0];
      wdata_d = req_wdata;
      add_d   = req_idx_s;
      d_in_d  = req_wdata;
    end else if ((state_q == ST_RWAIT) && op_wr_q) begin
      d_in_d = merged_s;
    end else begin
      d_in_d = d_in_q;
    end
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      resp_err_d   = (state_q == ST_IDLE);
      resp_rdata_d = ((state_q == ST_RWAIT) && !op_wr_q) ? load_data_s : 32'h0000_0000;
    end else begin
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_wr_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      add_q        <= '0;
      d_in_q       <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      op_wr_q      <= op_wr_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      add_q        <= add_d;
      d_in_q       <= d_in_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a registered-read
// memory model; a monitor checks responses and memory writes against queues.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        rd, wr;
  logic [31:0] add_lines, d_in, d_out;

  logic [31:0] mem [0:4095];

  typedef struct packed { logic [31:0] rdata; logic err; } resp_t;
  typedef struct packed { logic [31:0] idx; logic [31:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  load_store_unit dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .rd(rd), .wr(wr),
    .add_lines(add_lines), .d_in(d_in), .d_out(d_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (rd && add_lines < 32'd4096) d_out <= mem[add_lines[11:0]];
    if (wr && add_lines < 32'd4096) mem[add_lines[11:0]] <= d_in;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected responses and writes whenever the DUT presents them.
  initial begin
    resp_t er;
    wr_t   ew;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (rd || wr) check("rd_wr_exclusive", {63'd0, rd && wr}, 64'd0);
        if (rd) begin
          rd_cnt++;
          check("rd_single_cycle", {63'd0, prev_rd}, 64'd0);
        end
        if (wr) begin
          wr_cnt++;
          check("wr_single_cycle", {63'd0, prev_wr}, 64'd0);
          if (wr_q.size() == 0) begin
            check("wr_unexpected", 64'd1, 64'd0);
          end else begin
            ew = wr_q.pop_front();
            check("wr_add_lines", {32'd0, add_lines}, {32'd0, ew.idx});
            check("wr_d_in", {32'd0, d_in}, {32'd0, ew.data});
          end
        end
        if (resp_valid && resp_ready) begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", 64'd1, 64'd0);
          end else begin
            er = resp_q.pop_front();
            check("resp_rdata", {32'd0, resp_rdata}, {32'd0, er.rdata});
            check("resp_err", {63'd0, resp_err}, {63'd0, er.err});
          end
        end
        prev_rd = rd;
        prev_wr = wr;
      end
    end
  end

  // Issue one request from posedge+1 and wait until its response is taken.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [31:0] exp_wd, input int exp_lat,
                       input int exp_rds, input int exp_wrs, input int hold);
    int r0, w0, lat;
    logic [32:0] held;
    r0 = rd_cnt;
    w0 = wr_cnt;
    resp_q.push_back({exp_rd, exp_err});
    if (exp_wrs > 0) wr_q.push_back({addr >> 2, exp_wd});
    resp_ready = (hold == 0);
    req_wr = w; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge CLK);
    while (!resp_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("latency", lat, exp_lat);
    if (hold > 0) begin
      held = {resp_rdata, resp_err};
      check("bp_value", {31'd0, held}, {31'd0, exp_rd, exp_err});
      for (int i = 0; i < hold; i++) begin
        @(posedge CLK); #1;
        req_valid = (i % 2 == 0); req_wr = 1'b1; req_size = 2'b10;
        req_addr = 32'h20; req_wdata = 32'h5555_5555;
        @(negedge CLK);
        check("bp_valid", {63'd0, resp_valid}, 64'd1);
        check("bp_stable", {31'd0, resp_rdata, resp_err}, {31'd0, held});
        check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge CLK); #1;
    check("ready_after_resp", {63'd0, req_ready}, 64'd1);
    check("rd_count", rd_cnt - r0, exp_rds);
    check("wr_count", wr_cnt - w0, exp_wrs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_strobes", {60'd0, rd, wr, resp_valid, resp_err}, 64'd0);
    check("rst_add_din", {add_lines, d_in}, 64'd0);
    check("rst_rdata", {32'd0, resp_rdata}, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge CLK); #1;

    //    wr    size   sg    addr          wdata          exp_rdata      err   exp_write      lat rd wr hold
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 2, 0, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h1234_56A5, 32'h0000_0000, 1'b0, 32'hDEA5_BEEF, 4, 1, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_FFA5, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_00A5, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_DEA5, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 32'hDEA5_1234, 4, 1, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEA5_1234, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 2, 0, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3FFC, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0,         3, 1, 0, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 32'h0,         1, 0, 0, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h1111_1111, 32'h0000_0000, 1'b1, 32'h0,         1, 0, 0, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b1, 32'h0,         1, 0, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1, 32'h0,         1, 0, 0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h2222_2222, 32'h0000_0000, 1'b1, 32'h0,         1, 0, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEA5_1234, 1'b0, 32'h0,         3, 1, 0, 5);

    // Reset while the load sits in RWAIT: strobes drop, no response follows.
    req_wr = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("midrst_rd_phase", {63'd0, rd}, 64'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("midrst_strobes", {61'd0, rd, wr, resp_valid}, 64'd0);
    check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("midrst_no_resp", {62'd0, resp_valid, rd}, 64'd0);
    end
    @(posedge CLK); #1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEA5_1234, 1'b0, 32'h0,         3, 1, 0, 0);

    check("resp_queue_empty", resp_q.size(), 64'd0);
    check("wr_queue_empty", wr_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
